// File: rtl/alu_wb_master_pkg.sv
// Shared types and constants for the ALU Wishbone initiator.
// Mode/function selectors mirror the ALU slave's decode; state encodings are 3-bit.
package alu_wb_master_pkg;

  localparam logic       ALU_MODE_DSP          = 1'b0;
  localparam logic       ALU_MODE_FUNC         = 1'b1;
  localparam logic [7:0] ALU_FUNC_SIN          = 8'h01;
  localparam logic [7:0] ALU_FUNC_COS          = 8'h02;
  localparam logic [7:0] ALU_FUNC_INV_1_PLUS_X = 8'h03;

  localparam int unsigned W_OP  = 8;
  localparam int unsigned W_AB  = 18;
  localparam int unsigned W_C   = 48;
  localparam int unsigned W_CNT = 16;

  typedef enum logic [2:0] {
    ALU_WBM_ST_IDLE     = 3'd0,
    ALU_WBM_ST_STROBE   = 3'd1,
    ALU_WBM_ST_WAIT_ACK = 3'd2,
    ALU_WBM_ST_RESP     = 3'd3,
    ALU_WBM_ST_HOLD     = 3'd4
  } alu_wbm_state_e;

  typedef struct packed {
    logic             mode;
    logic [W_OP-1:0]  op;
    logic [W_AB-1:0]  al;
    logic [W_AB-1:0]  ar;
    logic [W_AB-1:0]  bl;
    logic [W_AB-1:0]  br;
    logic [W_C-1:0]   cl;
    logic [W_C-1:0]   cr;
  } alu_cmd_t;

  function automatic logic accepts_cmd(input alu_wbm_state_e s);
    return (s == ALU_WBM_ST_IDLE) || (s == ALU_WBM_ST_HOLD);
  endfunction

endpackage

// File: rtl/alu_wb_master_if.sv
// Client command/response channel plus ALU Wishbone slave port, bundled.
interface alu_wb_master_if;
  import alu_wb_master_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_last;
  logic             cmd_mode;
  logic [W_OP-1:0]  cmd_op;
  logic [W_AB-1:0]  cmd_al, cmd_ar, cmd_bl, cmd_br;
  logic [W_C-1:0]   cmd_cl, cmd_cr;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [W_C-1:0]   rsp_pl, rsp_pr;
  logic             rsp_err;

  logic             alu_cycle;
  logic             alu_strobe;
  logic             alu_ack;
  logic             alu_stall;
  logic             alu_mode;
  logic [W_OP-1:0]  alu_op;
  logic [W_AB-1:0]  alu_al, alu_ar, alu_bl, alu_br;
  logic [W_C-1:0]   alu_cl, alu_cr;
  logic [W_C-1:0]   alu_pl, alu_pr;

  modport master (
    input  cmd_valid, cmd_last, cmd_mode, cmd_op,
           cmd_al, cmd_ar, cmd_bl, cmd_br, cmd_cl, cmd_cr,
           rsp_ready, alu_ack, alu_stall, alu_pl, alu_pr,
    output cmd_ready, rsp_valid, rsp_pl, rsp_pr, rsp_err,
           alu_cycle, alu_strobe, alu_mode, alu_op,
           alu_al, alu_ar, alu_bl, alu_br, alu_cl, alu_cr
  );

  modport slave (
    output cmd_valid, cmd_last, cmd_mode, cmd_op,
           cmd_al, cmd_ar, cmd_bl, cmd_br, cmd_cl, cmd_cr,
           rsp_ready, alu_ack, alu_stall, alu_pl, alu_pr,
    input  cmd_ready, rsp_valid, rsp_pl, rsp_pr, rsp_err,
           alu_cycle, alu_strobe, alu_mode, alu_op,
           alu_al, alu_ar, alu_bl, alu_br, alu_cl, alu_cr
  );

endinterface

// File: rtl/alu_wb_master.sv
// Wishbone initiator for the ALU: one strobe per client command, CYC held across a burst.
// All outputs are registered so every one of them reads 0 while reset_n is low.
//
// state     | meaning
// IDLE      | no burst open, ready for a command
// STROBE    | single-cycle STB to the slave
// WAIT_ACK  | waiting for ACK, timeout counter running
// RESP      | result/error held until the client takes it
// HOLD      | burst still open (CYC high), ready for the next command
module alu_wb_master
  import alu_wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            reset_n,
  alu_wb_master_if.master bus
);

  localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(TIMEOUT_CYCLES - 1);

  alu_wbm_state_e   r_state, w_next;
  logic [W_CNT-1:0] r_cnt;
  alu_cmd_t         r_cmd;
  logic             r_last;
  logic             r_cmd_ready, r_rsp_valid, r_rsp_err;
  logic [W_C-1:0]   r_rsp_pl, r_rsp_pr;
  logic             r_alu_cycle, r_alu_strobe;

  logic             w_accept, w_rsp_hs, w_ack_hit, w_timeout, w_cycle_nxt;

  assign w_accept  = bus.cmd_valid && r_cmd_ready;
  assign w_rsp_hs  = r_rsp_valid && bus.rsp_ready;
  assign w_ack_hit = (r_state == ALU_WBM_ST_WAIT_ACK) && bus.alu_ack;
  // Ack takes priority over a timeout landing in the same cycle.
  assign w_timeout = (r_state == ALU_WBM_ST_WAIT_ACK) && !bus.alu_ack && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ALU_WBM_ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_cycle_nxt = r_alu_cycle;
    unique case (r_state)
      ALU_WBM_ST_IDLE, ALU_WBM_ST_HOLD: begin
        if (w_accept) begin
          w_next      = ALU_WBM_ST_STROBE;
          w_cycle_nxt = 1'b1;
        end
      end
      ALU_WBM_ST_STROBE: w_next = ALU_WBM_ST_WAIT_ACK;
      ALU_WBM_ST_WAIT_ACK: begin
        if (w_ack_hit) begin
          w_next = ALU_WBM_ST_RESP;
        end else if (w_timeout) begin
          w_next      = ALU_WBM_ST_RESP;
          w_cycle_nxt = 1'b0;
        end
      end
      ALU_WBM_ST_RESP: begin
        if (w_rsp_hs) begin
          if (r_last || r_rsp_err) begin
            w_next      = ALU_WBM_ST_IDLE;
            w_cycle_nxt = 1'b0;
          end else begin
            w_next = ALU_WBM_ST_HOLD;
          end
        end
      end
      default: begin
        w_next      = ALU_WBM_ST_IDLE;
        w_cycle_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_cmd        <= '0;
      r_last       <= 1'b0;
      r_cmd_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_pl     <= '0;
      r_rsp_pr     <= '0;
      r_alu_cycle  <= 1'b0;
      r_alu_strobe <= 1'b0;
    end else begin
      r_cmd_ready  <= accepts_cmd(w_next);
      r_alu_strobe <= (w_next == ALU_WBM_ST_STROBE);
      r_rsp_valid  <= (w_next == ALU_WBM_ST_RESP);
      r_alu_cycle  <= w_cycle_nxt;

      if (w_accept) begin
        r_cmd <= '{mode: bus.cmd_mode, op: bus.cmd_op,
                   al: bus.cmd_al, ar: bus.cmd_ar, bl: bus.cmd_bl, br: bus.cmd_br,
                   cl: bus.cmd_cl, cr: bus.cmd_cr};
        r_last <= bus.cmd_last;
      end

      if (r_state == ALU_WBM_ST_STROBE)        r_cnt <= '0;
      else if (r_state == ALU_WBM_ST_WAIT_ACK) r_cnt <= r_cnt + 1'b1;

      if (w_ack_hit) begin
        r_rsp_pl  <= bus.alu_pl;
        r_rsp_pr  <= bus.alu_pr;
        r_rsp_err <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_pl  <= '0;
        r_rsp_pr  <= '0;
        r_rsp_err <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.rsp_pl     = r_rsp_pl;
  assign bus.rsp_pr     = r_rsp_pr;
  assign bus.alu_cycle  = r_alu_cycle;
  assign bus.alu_strobe = r_alu_strobe;
  assign bus.alu_mode   = r_cmd.mode;
  assign bus.alu_op     = r_cmd.op;
  assign bus.alu_al     = r_cmd.al;
  assign bus.alu_ar     = r_cmd.ar;
  assign bus.alu_bl     = r_cmd.bl;
  assign bus.alu_br     = r_cmd.br;
  assign bus.alu_cl     = r_cmd.cl;
  assign bus.alu_cr     = r_cmd.cr;

endmodule

// File: tb/tb_alu_wb_master.sv
// Directed bench for alu_wb_master: slave model inline, results checked through a scoreboard queue.
module tb_alu_wb_master;
  import alu_wb_master_pkg::*;

  localparam int TO = 32;

  typedef struct {
    logic [47:0] pl;
    logic [47:0] pr;
    logic        err;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  int   n_checks = 0;
  int   n_errors = 0;
  int   strobe_cnt = 0;
  int   cyc_drops  = 0;
  int   unstable   = 0;
  bit   burst_mon  = 1'b0;
  bit   stab_mon   = 1'b0;
  alu_cmd_t snap;
  exp_t     sb[$];

  alu_wb_master_if bus ();

  alu_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic alu_cmd_t cur_alu();
    alu_cmd_t c;
    c = {bus.alu_mode, bus.alu_op, bus.alu_al, bus.alu_ar, bus.alu_bl, bus.alu_br,
         bus.alu_cl, bus.alu_cr};
    return c;
  endfunction

  function automatic logic any_out();
    return |{bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_pl, bus.rsp_pr,
             bus.alu_cycle, bus.alu_strobe, bus.alu_mode, bus.alu_op, bus.alu_al,
             bus.alu_ar, bus.alu_bl, bus.alu_br, bus.alu_cl, bus.alu_cr};
  endfunction

  function automatic alu_cmd_t mk(input logic mode, input logic [7:0] op,
                                  input logic [17:0] al, input logic [17:0] ar,
                                  input logic [17:0] bl, input logic [17:0] br,
                                  input logic [47:0] cl, input logic [47:0] cr);
    alu_cmd_t c;
    c = '{mode: mode, op: op, al: al, ar: ar, bl: bl, br: br, cl: cl, cr: cr};
    return c;
  endfunction

  // Result the bench's slave returns: P = A*B + C on each side.
  function automatic exp_t model(input alu_cmd_t c);
    exp_t e;
    e.pl  = 48'(c.al) * 48'(c.bl) + c.cl;
    e.pr  = 48'(c.ar) * 48'(c.br) + c.cr;
    e.err = 1'b0;
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (bus.alu_strobe) strobe_cnt++;
    if (burst_mon && !bus.alu_cycle) cyc_drops++;
    if (stab_mon && (cur_alu() !== snap)) unstable++;
  endtask

  // Offers a command, pushes its expectation, returns at the strobe cycle.
  task automatic send_cmd(input alu_cmd_t c, input logic last, input exp_t e);
    int w;
    bus.cmd_mode = c.mode; bus.cmd_op = c.op;
    bus.cmd_al = c.al; bus.cmd_ar = c.ar; bus.cmd_bl = c.bl; bus.cmd_br = c.br;
    bus.cmd_cl = c.cl; bus.cmd_cr = c.cr;
    bus.cmd_last  = last;
    bus.cmd_valid = 1'b1;
    w = 0;
    while (!bus.cmd_ready && w < 50) begin
      tick();
      w++;
    end
    chk("cmd_ready_offer", bus.cmd_ready, 1);
    sb.push_back(e);
    tick();
    bus.cmd_valid = 1'b0;
    chk("strobe_after_accept", bus.alu_strobe, 1);
    chk("operands_passthru", cur_alu() === c, 1);
    snap = c;
  endtask

  // Slave: optional stall, then a one-cycle ack `delay` cycles after the strobe.
  task automatic serve(input int delay, input logic stall);
    alu_cmd_t s;
    stab_mon = 1'b1;
    repeat (delay) begin
      bus.alu_stall = stall;
      tick();
    end
    bus.alu_stall = 1'b0;
    s = cur_alu();
    bus.alu_pl  = 48'(s.al) * 48'(s.bl) + s.cl;
    bus.alu_pr  = 48'(s.ar) * 48'(s.br) + s.cr;
    bus.alu_ack = 1'b1;
    tick();
    bus.alu_ack = 1'b0;
    stab_mon    = 1'b0;
  endtask

  task automatic wait_rsp(input int hold, output int waited);
    logic [47:0] pl0, pr0;
    logic        err0;
    int          bad, s0;
    waited = 0;
    while (!bus.rsp_valid && waited < 100) begin
      tick();
      waited++;
    end
    chk("rsp_valid_seen", bus.rsp_valid, 1);
    pl0 = bus.rsp_pl; pr0 = bus.rsp_pr; err0 = bus.rsp_err;
    s0  = strobe_cnt;
    bad = 0;
    repeat (hold) begin
      tick();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_pl !== pl0 || bus.rsp_pr !== pr0 ||
          bus.rsp_err !== err0 || bus.cmd_ready !== 1'b0) bad++;
    end
    if (hold > 0) begin
      chk("rsp_stable_backpressure", 64'(bad), 0);
      chk("no_strobe_backpressure", 64'(strobe_cnt - s0), 0);
    end
    chk("cmd_ready_low_in_resp", bus.cmd_ready, 0);
  endtask

  task automatic consume();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("rsp_pl", bus.rsp_pl, e.pl);
      chk("rsp_pr", bus.rsp_pr, e.pr);
      chk("rsp_err", bus.rsp_err, e.err);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    alu_cmd_t c;
    exp_t     e;
    int       waited, s0, seen;

    bus.cmd_valid = 0; bus.cmd_last = 0; bus.cmd_mode = 0; bus.cmd_op = '0;
    bus.cmd_al = '0; bus.cmd_ar = '0; bus.cmd_bl = '0; bus.cmd_br = '0;
    bus.cmd_cl = '0; bus.cmd_cr = '0; bus.rsp_ready = 0;
    bus.alu_ack = 0; bus.alu_stall = 0; bus.alu_pl = '0; bus.alu_pr = '0;

    repeat (3) tick();
    chk("reset_outputs_zero", any_out(), 0);
    reset_n = 1'b1;
    tick();
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    chk("idle_cycle_low", bus.alu_cycle, 0);

    // DSP op, single-command burst, exact latency
    c = mk(ALU_MODE_DSP, 8'h01, 18'h00100, 18'h0, 18'h00200, 18'h0, 48'h0, 48'h0);
    e = '{pl: 48'h20000, pr: 48'h0, err: 1'b0};
    s0 = strobe_cnt;
    send_cmd(c, 1'b1, e);
    serve(3, 1'b0);
    wait_rsp(0, waited);
    chk("dsp_latency_accept_to_rsp", 64'(waited), 0);
    consume();
    chk("dsp_cycle_low_after_hs", bus.alu_cycle, 0);
    chk("dsp_strobe_count", 64'(strobe_cnt - s0), 1);

    // SIN op with 20 stall cycles before ack
    c = mk(ALU_MODE_FUNC, ALU_FUNC_SIN, 18'h01234, 18'h00007, 18'h00003, 18'h00011,
           48'h5, 48'h100);
    s0 = strobe_cnt; unstable = 0;
    send_cmd(c, 1'b1, model(c));
    serve(20, 1'b1);
    wait_rsp(0, waited);
    consume();
    chk("sin_strobe_count", 64'(strobe_cnt - s0), 1);
    chk("sin_operands_stable", 64'(unstable), 0);

    // Three-command burst; middle op acked on the last legal cycle
    s0 = strobe_cnt; cyc_drops = 0;
    c = mk(ALU_MODE_DSP, 8'h02, 18'h3FFFF, 18'h00002, 18'h3FFFF, 18'h00003, 48'h1, 48'h2);
    send_cmd(c, 1'b0, model(c));
    burst_mon = 1'b1;
    serve(2, 1'b0);
    wait_rsp(0, waited);
    consume();
    chk("burst_hold_ready", bus.cmd_ready, 1);
    chk("burst_hold_cycle", bus.alu_cycle, 1);
    c = mk(ALU_MODE_FUNC, ALU_FUNC_COS, 18'h00ABC, 18'h00DEF, 18'h00010, 18'h00020,
           48'hFFFF_0000_0000, 48'h0);
    send_cmd(c, 1'b0, model(c));
    serve(TO, 1'b1);
    wait_rsp(0, waited);
    consume();
    c = mk(ALU_MODE_DSP, 8'h05, 18'h00009, 18'h0000A, 18'h0000B, 18'h0000C, 48'h0, 48'h7);
    send_cmd(c, 1'b1, model(c));
    serve(4, 1'b0);
    wait_rsp(0, waited);
    burst_mon = 1'b0;
    consume();
    chk("burst_cycle_continuous", 64'(cyc_drops), 0);
    chk("burst_strobe_count", 64'(strobe_cnt - s0), 3);
    chk("burst_cycle_low_after", bus.alu_cycle, 0);

    // Client back-pressure for 10 cycles
    c = mk(ALU_MODE_DSP, 8'h03, 18'h00021, 18'h00022, 18'h00023, 18'h00024, 48'h9, 48'hA);
    send_cmd(c, 1'b1, model(c));
    serve(3, 1'b0);
    wait_rsp(10, waited);
    consume();

    // Timeout: slave never acks; stray acks afterwards must be ignored
    c = mk(ALU_MODE_FUNC, ALU_FUNC_INV_1_PLUS_X, 18'h00055, 18'h0, 18'h0, 18'h0, 48'h0, 48'h0);
    e = '{pl: 48'h0, pr: 48'h0, err: 1'b1};
    s0 = strobe_cnt;
    send_cmd(c, 1'b0, e);
    wait_rsp(0, waited);
    chk("timeout_cycles_to_rsp", 64'(waited), 64'(TO + 1));
    chk("timeout_cycle_dropped", bus.alu_cycle, 0);
    bus.alu_pl = '1; bus.alu_pr = '1; bus.alu_ack = 1'b1;
    tick();
    bus.alu_ack = 1'b0;
    consume();
    chk("timeout_idle_ready", bus.cmd_ready, 1);
    chk("timeout_cycle_low_after", bus.alu_cycle, 0);
    bus.alu_ack = 1'b1;
    tick();
    bus.alu_ack = 1'b0;
    seen = 0;
    repeat (3) begin
      tick();
      if (bus.rsp_valid) seen++;
    end
    chk("late_ack_no_rsp", 64'(seen), 0);
    chk("late_ack_no_strobe", 64'(strobe_cnt - s0), 1);
    c = mk(ALU_MODE_DSP, 8'h01, 18'h00004, 18'h00005, 18'h00006, 18'h00007, 48'h0, 48'h0);
    send_cmd(c, 1'b1, model(c));
    serve(3, 1'b0);
    wait_rsp(0, waited);
    chk("post_timeout_latency", 64'(waited), 0);
    consume();

    // Reset asserted during WAIT_ACK
    c = mk(ALU_MODE_DSP, 8'h07, 18'h00111, 18'h00222, 18'h00333, 18'h00444, 48'h5, 48'h6);
    send_cmd(c, 1'b0, model(c));
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("midop_reset_outputs_zero", any_out(), 0);
    chk("midop_reset_cycle_low", bus.alu_cycle, 0);
    void'(sb.pop_back());
    tick();
    reset_n = 1'b1;
    seen = 0;
    repeat (6) begin
      tick();
      if (bus.rsp_valid) seen++;
    end
    chk("midop_reset_no_rsp", 64'(seen), 0);
    chk("midop_reset_idle_ready", bus.cmd_ready, 1);
    chk("scoreboard_drained", 64'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
